// File: rtl/mem_access_ctrl.sv
// Byte/halfword/word load-store sequencer over a big-endian word memory; sub-word stores read-modify-write.
// Optional alignment trap when MEM_ACC_ALIGN_CHECK_EN is defined (default build: unaligned accesses proceed, err=0).
module mem_access_ctrl #(
  parameter int ADDR_W = 15,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, we_d, uns_q, uns_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic              misalign;
  logic [31:0]       load_val, merge_val;

`ifdef MEM_ACC_ALIGN_CHECK_EN
  logic err_q;
  assign misalign = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
  assign err      = err_q;

  // Set only on a trapped acceptance, so it is high exactly during that DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (state_q == IDLE) && req && misalign;
  end
`else
  assign misalign = 1'b0;
  assign err      = 1'b0;
`endif

  // Byte 0 of the big-endian word sits in the top lane.
  always_comb begin
    load_val  = mem_rdata;
    merge_val = wdata_q;
    case (size_q)
      2'b00: begin
        load_val  = {{24{~uns_q & mem_rdata[31]}}, mem_rdata[31:24]};
        merge_val = {wdata_q[7:0], mem_rdata[23:0]};
      end
      2'b01: begin
        load_val  = {{16{~uns_q & mem_rdata[31]}}, mem_rdata[31:16]};
        merge_val = {wdata_q[15:0], mem_rdata[15:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    uns_d       = uns_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_wdata_d = mem_wdata_q;
    mem_addr_d  = mem_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (req) begin
          we_d    = we;
          uns_d   = uns;
          size_d  = size;
          wdata_d = wdata;
          busy_d  = 1'b1;
          cnt_d   = 3'd0;
          if (misalign) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (we && size[1]) begin
            state_d     = WRITE;
            mem_addr_d  = addr;
            mem_wdata_d = wdata;
            mem_write_d = 1'b1;
          end else begin
            state_d    = READ;
            mem_addr_d = addr;
            mem_read_d = 1'b1;
          end
        end
      end
      READ: begin
        if (cnt_q == 3'(RD_LAT - 1)) begin
          if (we_q) begin
            state_d     = WRITE;
            mem_wdata_d = merge_val;
            mem_write_d = 1'b1;
          end else begin
            state_d = DONE;
            rdata_d = load_val;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d      = cnt_q + 3'd1;
          mem_read_d = 1'b1;
        end
      end
      WRITE: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_wdata_q <= mem_wdata_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases, then random accesses against a byte-array memory model.
module tb_mem_access_ctrl;
  localparam int ADDR_W = 15;
  localparam int RD_LAT = 1;
  localparam int MSIZE  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]        size = 2'b00;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wdata = 32'd0;
  logic [31:0]       rdata, mem_wdata, mem_rdata;
  logic              busy, done, err, mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;

  logic [7:0]  mem [MSIZE];  // memory seen by the DUT
  logic [7:0]  mm  [MSIZE];  // reference byte image
  int          errors = 0, checks = 0, both_hi = 0;
  logic [31:0] last_load = 32'd0, last_wr = 32'd0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata));

  function automatic logic [31:0] dut_word(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] a1, a2, a3;
    a1 = a + 1'b1; a2 = a + 2'd2; a3 = a + 2'd3;
    return {mem[a], mem[a1], mem[a2], mem[a3]};
  endfunction

  function automatic logic [31:0] model_word(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] a1, a2, a3;
    a1 = a + 1'b1; a2 = a + 2'd2; a3 = a + 2'd3;
    return {mm[a], mm[a1], mm[a2], mm[a3]};
  endfunction

  assign mem_rdata = dut_word(mem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic w, input logic [1:0] sz, input logic u,
                       input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    logic [ADDR_W-1:0] a1, a2, a3;
    logic        mis;
    int          exp_lat, lat, rd_cyc, wr_cyc;
    logic [31:0] word, exp_rdata;
    a1 = a + 1'b1; a2 = a + 2'd2; a3 = a + 2'd3;
    mis = 1'b0;
`ifdef MEM_ACC_ALIGN_CHECK_EN
    mis = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`endif
    word = model_word(a);
    exp_rdata = last_load;
    if (mis)               exp_lat = 1;
    else if (w && sz[1])   exp_lat = 2;
    else if (w)            exp_lat = RD_LAT + 2;
    else                   exp_lat = RD_LAT + 1;
    if (!w && !mis) begin
      case (sz)
        2'b00:   exp_rdata = u ? {24'd0, word[31:24]} : 32'(signed'(word[31:24]));
        2'b01:   exp_rdata = u ? {16'd0, word[31:16]} : 32'(signed'(word[31:16]));
        default: exp_rdata = word;
      endcase
    end
    if (w && !mis) begin
      case (sz)
        2'b00:   mm[a] = wd[7:0];
        2'b01:   begin mm[a] = wd[15:8]; mm[a1] = wd[7:0]; end
        default: begin mm[a] = wd[31:24]; mm[a1] = wd[23:16]; mm[a2] = wd[15:8]; mm[a3] = wd[7:0]; end
      endcase
    end
    @(negedge clk);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0; addr = ADDR_W'($urandom); wdata = $urandom; uns = ~u;
    lat = 0; rd_cyc = 0; wr_cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_after_accept", {31'd0, busy}, 32'd1);
      if (mem_read && mem_write) both_hi++;
      if (mem_read) rd_cyc++;
      if (mem_write) begin
        wr_cyc++;
        last_wr = mem_wdata;
        {mem[mem_addr], mem[mem_addr + 1'b1], mem[mem_addr + 2'd2], mem[mem_addr + 2'd3]} = mem_wdata;
      end
      if (done) begin lat = k; break; end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("read_cycles", 32'(rd_cyc), (mis || (w && sz[1])) ? 32'd0 : 32'(RD_LAT));
    check("write_cycles", 32'(wr_cyc), (w && !mis) ? 32'd1 : 32'd0);
    check("err", {31'd0, err}, {31'd0, mis});
    check("rdata", rdata, exp_rdata);
    last_load = exp_rdata;
    if (w && !mis) check("written_word", last_wr, model_word(a));
  endtask

  initial begin
    for (int i = 0; i < MSIZE; i++) begin
      mem[i] = 8'($urandom);
      mm[i]  = mem[i];
    end
    {mem[16], mem[17], mem[18], mem[19], mem[20]} = 40'h80_11_22_33_44;
    {mm[16],  mm[17],  mm[18],  mm[19],  mm[20]}  = 40'h80_11_22_33_44;
    #3;
    check("rst_outputs", {26'd0, busy, done, err, mem_read, mem_write, 1'b0}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b0, 2'b00, 1'b0, 15'h10, 32'd0);
    check("byte_load_0x10", rdata, 32'hFFFF_FF80);
    do_op(1'b0, 2'b01, 1'b1, 15'h10, 32'd0);
    check("half_load_0x10", rdata, 32'h0000_8011);
    do_op(1'b1, 2'b00, 1'b0, 15'h11, 32'h0000_00AB);
    check("byte_store_word", last_wr, 32'hAB22_3344);
    do_op(1'b1, 2'b10, 1'b0, 15'h20, 32'hDEAD_BEEF);
    check("word_store_word", last_wr, 32'hDEAD_BEEF);

    // Reset during the WRITE cycle of a word store: nothing lands, no done.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 15'h40; wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    req = 1'b0;
    check("write_cycle_entered", {31'd0, mem_write}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_kills_write", {29'd0, mem_write, done, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("no_done_after_abort", {31'd0, done}, 32'd0);
    last_load = 32'd0;
    do_op(1'b0, 2'b10, 1'b0, 15'h40, 32'd0);

    for (int n = 0; n < 60; n++) begin
      logic [ADDR_W-1:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? ADDR_W'(15'h7FFC + $urandom_range(0, 3))
                                       : ADDR_W'($urandom_range(0, 63));
      do_op(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom);
    end

    check("read_write_exclusive", 32'(both_hi), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 15, byte-address width on both the CPU side and the memory side.
REQ-002 Parameter: RD_LAT, default 1, range 1-7, cycles mem_read is held before mem_rdata is sampled.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  in  1  single clock, rising edge.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: req  in  1  access request, sampled only in IDLE.
REQ-007 Port: we  in  1  1=store, 0=load.
REQ-008 Port: size  in  2  00=byte, 01=halfword, 10=word; 11 is treated as word.
REQ-009 Port: uns  in  1  1=zero-extend loads, 0=sign-extend loads.
REQ-010 Port: addr  in  ADDR_W  byte address.
REQ-011 Port: wdata  in  32  store data, right-justified for byte and halfword.
REQ-012 Port: rdata  out  32  load result, valid while done=1 and held until the next load completes.
REQ-013 Port: busy  out  1  high from the cycle after acceptance until the return to IDLE.
REQ-014 Port: done  out  1  one-cycle completion pulse.
REQ-015 Port: err  out  1  alignment error, qualified by done; tied 0 when the feature is compiled out.
REQ-016 Port: mem_addr  out  ADDR_W  memory address.
REQ-017 Port: mem_wdata  out  32  memory write word.
REQ-018 Port: mem_read  out  1  memory read enable.
REQ-019 Port: mem_write  out  1  memory write enable.
REQ-020 Port: mem_rdata  in  32  big-endian word: bits [31:24] are the byte at mem_addr.

Function
REQ-021 States are IDLE, READ, WRITE and DONE; all outputs shall be registered.
REQ-022 IDLE with req=1 shall latch addr, we, size, uns and wdata, then go to WRITE for a word store or to READ otherwise.
REQ-023 READ shall hold mem_read=1 and mem_addr=latched addr for RD_LAT cycles, then sample mem_rdata on the last cycle.
REQ-024 At the end of READ, a load shall go to DONE and a sub-word store shall go to WRITE.
REQ-025 Load extraction: byte=mem_rdata[31:24], halfword=[31:16], word=all 32 bits; extension per uns.
REQ-026 Sub-word store merge: byte replaces [31:24] of the sampled word with wdata[7:0]; halfword replaces [31:16] with wdata[15:0]; all other bits are kept.
REQ-027 WRITE shall assert mem_write=1 for exactly one cycle with mem_wdata = merged word (or wdata for a word store), then go to DONE.
REQ-028 DONE shall assert done=1 for one cycle, then return to IDLE.
REQ-029 Latency from the req edge to done: word store = 2 cycles; load = RD_LAT+1 cycles; sub-word store = RD_LAT+2 cycles.
REQ-030 req outside IDLE shall be ignored and never queued; a req held high through DONE is accepted again in the following IDLE cycle.
REQ-031 mem_read and mem_write shall never be high in the same cycle.
REQ-032 Address arithmetic is modulo 2^ADDR_W; the memory performs lane wrap for unaligned accesses.

Reset
REQ-033 On rst_n=0, asynchronously: state=IDLE; busy, done, err, mem_read and mem_write = 0; rdata, mem_addr and mem_wdata = 0.
REQ-034 Reset during READ or WRITE shall abort the access with no done pulse; a mem_write cycle cut by reset is not retried.

Configuration
REQ-035 Macro MEM_ACC_ALIGN_CHECK_EN, when defined: halfword with addr[0]=1, or word with addr[1:0]!=0, goes directly from IDLE to DONE with err=1, no memory access, and rdata unchanged.
REQ-036 Without MEM_ACC_ALIGN_CHECK_EN: unaligned accesses proceed normally and err is constant 0.

Verification
REQ-037 RD_LAT=1; mem[0x10..0x13]=80 11 22 33; byte load, uns=0, addr=0x10 -> done at cycle 2, rdata=0xFFFFFF80.
REQ-038 Same memory; halfword load, uns=1, addr=0x10 -> rdata=0x00008011.
REQ-039 Byte store wdata=0xAB at 0x11 with mem[0x11..0x14]=11 22 33 44 -> one read then one write of 0xAB223344; done at cycle 3.
REQ-040 Word store 0xDEADBEEF at 0x20 -> mem_read never asserts; mem_write pulses once; done at cycle 2.
REQ-041 rst_n low during a WRITE cycle -> mem_write=0 immediately, no done, state IDLE; next req is accepted normally.
REQ-042 With MEM_ACC_ALIGN_CHECK_EN, word load at 0x22 -> done=1 and err=1 in cycle 1, with no mem_read and no mem_write.
